// File: rtl/nfc_rng_pkg.sv
// Shared encodings and default constants for the NFC random/pattern word source.
package nfc_rng_pkg;

    typedef enum logic [1:0] {
        RNG_LFSR = 2'b00,
        RNG_HOLD = 2'b01,
        RNG_INC  = 2'b10,
        RNG_DEC  = 2'b11
    } rng_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } rng_state_e;

    localparam logic [31:0] RNG_POLY_DFLT = 32'h8000_0057;
    localparam logic [31:0] RNG_SEED_DFLT = 32'h0000_0001;

endpackage

// File: rtl/nfc_rng_core.sv
// Generator state register with per-mode next-state function (LFSR, hold, inc, dec).
module nfc_rng_core
    import nfc_rng_pkg::*;
#(
    parameter int unsigned       LFSR_W    = 32,
    parameter logic [LFSR_W-1:0] POLY      = LFSR_W'(RNG_POLY_DFLT),
    parameter int unsigned       STEP      = 1,
    parameter logic [LFSR_W-1:0] SEED_DFLT = LFSR_W'(RNG_SEED_DFLT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    input  rng_mode_e         mode,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q, state_d;
    rng_mode_e         mode_q, mode_d;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        if (load) begin
            mode_d = mode;
            // An all-zero LFSR would lock up, so substitute the default seed.
            if (seed == '0 && mode == RNG_LFSR) begin
                state_d = SEED_DFLT;
            end else begin
                state_d = seed;
            end
        end else if (step) begin
            unique case (mode_q)
                RNG_LFSR: state_d = {state_q[LFSR_W-2:0], ^(state_q & POLY)};
                RNG_HOLD: state_d = state_q;
                RNG_INC:  state_d = state_q + LFSR_W'(STEP);
                RNG_DEC:  state_d = state_q - LFSR_W'(STEP);
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            mode_q  <= RNG_LFSR;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/nfc_rng_gen.sv
// Word source: slices the generator state MSB first behind a valid/ready handshake,
// with an optional word count that ends the run with a one-cycle done pulse.
module nfc_rng_gen
    import nfc_rng_pkg::*;
#(
    parameter int unsigned       LFSR_W    = 32,
    parameter int unsigned       DAT_W     = 16,
    parameter logic [LFSR_W-1:0] POLY      = LFSR_W'(RNG_POLY_DFLT),
    parameter int unsigned       STEP      = 1,
    parameter logic [LFSR_W-1:0] SEED_DFLT = LFSR_W'(RNG_SEED_DFLT),
    parameter int unsigned       LEN_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              rd,
    input  logic [LFSR_W-1:0] seed,
    input  logic [1:0]        mode,
    input  logic [LEN_W-1:0]  len,
    output logic [DAT_W-1:0]  rng_dat,
    output logic              rng_vld,
    output logic              done
);

    localparam int unsigned SLICES = LFSR_W / DAT_W;
    localparam int unsigned IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLICES - 1);

    rng_state_e        fsm_q, fsm_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_inc;
    logic              en_dly_q;
    logic              done_q, done_d;
    logic              load, xfer, step;
    logic [LFSR_W-1:0] state;

    assign load    = en & ~en_dly_q;
    assign rng_vld = (fsm_q == RUN);
    assign xfer    = rd & rng_vld;
    assign cnt_inc = cnt_q + LEN_W'(1);
    // Advance the generator only once the last (least significant) slice is consumed.
    assign step    = en & ~load & xfer & (idx_q == '0);

    nfc_rng_core #(
        .LFSR_W    (LFSR_W),
        .POLY      (POLY),
        .STEP      (STEP),
        .SEED_DFLT (SEED_DFLT)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .seed  (seed),
        .mode  (rng_mode_e'(mode)),
        .state (state)
    );

    always_comb begin
        fsm_d  = fsm_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        done_d = 1'b0;
        if (!en) begin
            fsm_d = IDLE;
            idx_d = IDX_LAST;
        end else if (load) begin
            fsm_d = RUN;
            idx_d = IDX_LAST;
            cnt_d = '0;
            len_d = len;
        end else if (xfer) begin
            cnt_d = cnt_inc;
            idx_d = (idx_q != '0) ? idx_q - IDX_W'(1) : IDX_LAST;
            if (len_q != '0 && cnt_inc == len_q) begin
                fsm_d  = DONE;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            idx_q    <= IDX_LAST;
            cnt_q    <= '0;
            len_q    <= '0;
            en_dly_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            en_dly_q <= en;
            done_q   <= done_d;
        end
    end

    assign rng_dat = state[idx_q*DAT_W +: DAT_W];
    assign done    = done_q;

endmodule
